// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | servo_pkg: shared widths, default servo limits and clamp helper.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package servo_pkg;

    localparam int US_W          = 16;
    localparam int DEF_MIN_US    = 1000;
    localparam int DEF_MAX_US    = 2000;
    localparam int DEF_CENTER_US = 1500;

    function automatic logic [US_W-1:0] clamp_us(
        input logic [US_W-1:0] val,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | servo_pwm_gen_if: core-side control and status bundle for the servo. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface servo_pwm_gen_if;

    logic                          i_en;
    logic                          i_wr_en;
    logic [servo_pkg::US_W-1:0]    i_wr_data;
    logic                          o_pwm;
    logic                          o_frame_start;
    logic                          o_at_target;
    logic [servo_pkg::US_W-1:0]    o_cur_width;

    modport master (
        output i_en, i_wr_en, i_wr_data,
        input  o_pwm, o_frame_start, o_at_target, o_cur_width
    );

    modport slave (
        input  i_en, i_wr_en, i_wr_data,
        output o_pwm, o_frame_start, o_at_target, o_cur_width
    );

endinterface
`default_nettype wire

// File: rtl/us_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | us_tick_gen: divides the core clock down to a 1 us enable strobe.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module us_tick_gen #(
    parameter int DIV = 25
) (
    input  wire logic clk_core,
    input  wire logic rst_core,
    input  wire logic i_en,
    output logic      o_tick
);

    localparam int               CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    // With DIV==1 the counter never leaves 0, so the tick follows i_en.
    assign w_last = (r_cnt == C_LAST);
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | servo_pwm_gen: slew-limited servo PWM with clamped width target.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = DEF_MIN_US,
    parameter int MAX_US      = DEF_MAX_US,
    parameter int CENTER_US   = DEF_CENTER_US,
    parameter int STEP_US     = 10
) (
    input  wire logic        clk_core,
    input  wire logic        rst_core,
    servo_pwm_gen_if.slave   bus
);

    localparam int              DIV           = CLK_FREQ_HZ / 1_000_000;
    localparam logic [US_W-1:0] C_PERIOD_LAST = US_W'(PERIOD_US - 1);
    localparam logic [US_W-1:0] C_MIN         = US_W'(MIN_US);
    localparam logic [US_W-1:0] C_MAX         = US_W'(MAX_US);
    localparam logic [US_W-1:0] C_CENTER      = US_W'(CENTER_US);
    localparam logic [US_W-1:0] C_STEP        = US_W'(STEP_US);

    logic            w_tick;
    logic            w_wrap;
    logic [US_W:0]   w_diff;
    logic [US_W:0]   w_abs;
    logic [US_W-1:0] w_next_target;
    logic [US_W-1:0] w_next_cur;

    logic [US_W-1:0] r_target;
    logic [US_W-1:0] r_cur;
    logic [US_W-1:0] r_us_cnt;
    logic            r_pwm;
    logic            r_frame_start;
    logic            r_at_target;

    us_tick_gen #(
        .DIV      (DIV)
    ) u_tick (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .i_en     (bus.i_en),
        .o_tick   (w_tick)
    );

    assign w_wrap = w_tick && (r_us_cnt == C_PERIOD_LAST);

    // Slew compares against the target held before this edge, so a write
    // landing on a boundary cycle only influences the following boundary.
    always_comb begin
        w_next_target = r_target;
        if (bus.i_wr_en) begin
            w_next_target = clamp_us(bus.i_wr_data, C_MIN, C_MAX);
        end

        w_diff = {1'b0, r_target} - {1'b0, r_cur};
        w_abs  = w_diff[US_W] ? (~w_diff + 1'b1) : w_diff;

        w_next_cur = r_cur;
        if (w_wrap) begin
            if ((C_STEP == '0) || (w_abs <= {1'b0, C_STEP})) begin
                w_next_cur = r_target;
            end else if (w_diff[US_W]) begin
                w_next_cur = r_cur - C_STEP;
            end else begin
                w_next_cur = r_cur + C_STEP;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_target      <= C_CENTER;
            r_cur         <= C_CENTER;
            r_us_cnt      <= '0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_at_target   <= 1'b1;
        end else begin
            r_target      <= w_next_target;
            r_cur         <= w_next_cur;
            r_at_target   <= (w_next_cur == w_next_target);
            r_frame_start <= w_wrap;
            r_pwm         <= bus.i_en && (r_us_cnt < r_cur);
            if (!bus.i_en || w_wrap) begin
                r_us_cnt <= '0;
            end else if (w_tick) begin
                r_us_cnt <= r_us_cnt + 1'b1;
            end
        end
    end

    assign bus.o_pwm         = r_pwm;
    assign bus.o_frame_start = r_frame_start;
    assign bus.o_at_target   = r_at_target;
    assign bus.o_cur_width   = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_servo_pwm_gen: directed vector table plus multi-frame sequences.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_servo_pwm_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    servo_pwm_gen_if bus  ();
    servo_pwm_gen_if bus0 ();

    assign bus0.i_en = bus.i_en;

    servo_pwm_gen #(
        .CLK_FREQ_HZ (1_000_000), .PERIOD_US (100), .MIN_US (10),
        .MAX_US      (60),        .CENTER_US (30),  .STEP_US (5)
    ) dut (
        .clk_core (clk),
        .rst_core (rst),
        .bus      (bus)
    );

    // Second instance jumps straight to the target, used for clamp checks.
    servo_pwm_gen #(
        .CLK_FREQ_HZ (1_000_000), .PERIOD_US (100), .MIN_US (10),
        .MAX_US      (60),        .CENTER_US (30),  .STEP_US (0)
    ) dut0 (
        .clk_core (clk),
        .rst_core (rst),
        .bus      (bus0)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        wr;
        logic [15:0] data;
        int          cycles;
        logic        pwm;
        logic        fs;
        logic        at;
        logic [15:0] cur;
    } vec_t;

    vec_t tbl [23];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr1(input logic [15:0] d);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = d;
        step();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic wr0(input logic [15:0] d);
        bus0.i_wr_en   = 1'b1;
        bus0.i_wr_data = d;
        step();
        bus0.i_wr_en   = 1'b0;
    endtask

    task automatic wait_fs(input bit which, input string name);
        int k   = 0;
        bit got = 1'b0;
        while (!got && k < 200) begin
            step();
            k++;
            got = which ? bus0.o_frame_start : bus.o_frame_start;
        end
        check(name, got, 1);
    endtask

    task automatic measure(input bit which, input int exp, input string name);
        int cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            cnt += int'(which ? bus0.o_pwm : bus.o_pwm);
        end
        check(name, cnt, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;

        rst            = 1'b1;
        bus.i_en       = 1'b0;
        bus.i_wr_en    = 1'b0;
        bus.i_wr_data  = '0;
        bus0.i_wr_en   = 1'b0;
        bus0.i_wr_data = '0;

        //           rst en wr data  cyc pwm fs at cur
        tbl[0]  = '{1, 0, 0, 0,   2,   0, 0, 1, 30};
        tbl[1]  = '{0, 1, 0, 0,   1,   1, 0, 1, 30};
        tbl[2]  = '{0, 1, 0, 0,   29,  1, 0, 1, 30};
        tbl[3]  = '{0, 1, 0, 0,   1,   0, 0, 1, 30};
        tbl[4]  = '{0, 1, 0, 0,   69,  0, 1, 1, 30};
        tbl[5]  = '{0, 1, 0, 0,   1,   1, 0, 1, 30};
        tbl[6]  = '{0, 1, 1, 50,  1,   1, 0, 0, 30};
        tbl[7]  = '{0, 1, 0, 0,   98,  0, 1, 0, 35};
        tbl[8]  = '{0, 1, 0, 0,   35,  1, 0, 0, 35};
        tbl[9]  = '{0, 1, 0, 0,   1,   0, 0, 0, 35};
        tbl[10] = '{0, 1, 0, 0,   64,  0, 1, 0, 40};
        tbl[11] = '{0, 1, 0, 0,   40,  1, 0, 0, 40};
        tbl[12] = '{0, 1, 0, 0,   1,   0, 0, 0, 40};
        tbl[13] = '{0, 1, 0, 0,   59,  0, 1, 0, 45};
        tbl[14] = '{0, 1, 0, 0,   100, 0, 1, 1, 50};
        tbl[15] = '{0, 1, 0, 0,   50,  1, 0, 1, 50};
        tbl[16] = '{0, 1, 0, 0,   1,   0, 0, 1, 50};
        tbl[17] = '{0, 1, 0, 0,   48,  0, 0, 1, 50};
        tbl[18] = '{0, 1, 1, 42,  1,   0, 1, 0, 50};
        tbl[19] = '{0, 1, 0, 0,   100, 0, 1, 0, 45};
        tbl[20] = '{0, 1, 0, 0,   100, 0, 1, 1, 42};
        tbl[21] = '{0, 1, 0, 0,   42,  1, 0, 1, 42};
        tbl[22] = '{0, 1, 0, 0,   1,   0, 0, 1, 42};

        for (int i = 0; i < 23; i++) begin
            rst           = tbl[i].rst;
            bus.i_en      = tbl[i].en;
            bus.i_wr_en   = tbl[i].wr;
            bus.i_wr_data = tbl[i].data;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                step();
                bus.i_wr_en = 1'b0;
            end
            check($sformatf("vec%0d pwm", i), bus.o_pwm, tbl[i].pwm);
            check($sformatf("vec%0d frame_start", i), bus.o_frame_start, tbl[i].fs);
            check($sformatf("vec%0d at_target", i), bus.o_at_target, tbl[i].at);
            check($sformatf("vec%0d cur_width", i), bus.o_cur_width, tbl[i].cur);
        end

        // Clamping on the jump-to-target instance.
        wr0(16'd5);
        check("clamp5 at_target", bus0.o_at_target, 0);
        wait_fs(1'b1, "clamp5 boundary");
        check("clamp5 cur", bus0.o_cur_width, 10);
        check("clamp5 at_target settled", bus0.o_at_target, 1);
        wr0(16'hFFFF);
        wait_fs(1'b1, "clampFFFF boundary");
        check("clampFFFF cur", bus0.o_cur_width, 60);
        wr0(16'd30);
        wait_fs(1'b1, "back30 boundary");
        check("back30 cur", bus0.o_cur_width, 30);
        wr0(16'd200);
        wait_fs(1'b1, "clamp200 boundary");
        check("clamp200 cur", bus0.o_cur_width, 60);
        measure(1'b1, 60, "clamp200 pulse len");

        // Enable drop mid-pulse with a slew pending.
        wr1(16'd60);
        check("en target60 at_target", bus.o_at_target, 0);
        wait_fs(1'b0, "en boundary");
        check("en slew cur", bus.o_cur_width, 47);
        for (int k = 0; k < 10; k++) step();
        check("en mid-pulse pwm", bus.o_pwm, 1);
        bus.i_en = 1'b0;
        step();
        check("en off pwm", bus.o_pwm, 0);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            bad += int'(bus.o_pwm) + int'(bus.o_frame_start);
        end
        check("disabled activity", bad, 0);
        check("disabled cur frozen", bus.o_cur_width, 47);
        check("disabled at_target", bus.o_at_target, 0);
        wr1(16'd47);
        check("write while disabled", bus.o_at_target, 1);
        bus.i_en = 1'b1;
        step();
        check("reenable pwm", bus.o_pwm, 1);
        check("reenable no frame_start", bus.o_frame_start, 0);
        cnt = 1;
        for (int k = 0; k < 99; k++) begin
            step();
            cnt += int'(bus.o_pwm);
        end
        check("reenable pulse len", cnt, 47);
        check("reenable frame end", bus.o_frame_start, 1);

        // Reset while slewing from 45 toward 60.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset0 cur", bus.o_cur_width, 30);
        wr1(16'd60);
        wait_fs(1'b0, "slew b1");
        check("slew b1 cur", bus.o_cur_width, 35);
        wait_fs(1'b0, "slew b2");
        check("slew b2 cur", bus.o_cur_width, 40);
        wait_fs(1'b0, "slew b3");
        check("slew b3 cur", bus.o_cur_width, 45);
        for (int k = 0; k < 10; k++) step();
        check("pre-reset pwm", bus.o_pwm, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset pwm", bus.o_pwm, 0);
        check("reset cur", bus.o_cur_width, 30);
        check("reset at_target", bus.o_at_target, 1);
        check("reset frame_start", bus.o_frame_start, 0);
        measure(1'b0, 30, "post-reset pulse len");
        check("post-reset frame end", bus.o_frame_start, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
